mac_operand_feeder: RTL and testbench

Upstream stage for the sequential multiply-accumulate unit (the unit with operands a/b, a start input, a busy output, and ab/acc results).
- Accepts signed operand pairs over a valid/ready interface and buffers them in a small FIFO.
- Issues one start handshake per pair to the MAC, holding a/b stable for the whole operation.
- Counts completed operations and flags a MAC that never acknowledges start.

---
 rtl/mac_pkg.sv | 15 +
 rtl/mac_operand_feeder_if.sv | 12 +
 rtl/operand_fifo.sv | 51 +++++
 rtl/mac_operand_feeder.sv | 125 ++++++++++++
 tb/tb_mac_operand_feeder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC operand feeder and its sub-blocks.
package mac_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int DEPTH_DEF        = 4;
  localparam int BUSY_TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF        = 16;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    RUN
  } feeder_state_t;

endpackage

// File: rtl/mac_operand_feeder_if.sv
// Upstream operand-pair stream: valid/ready with signed a/b operands.
interface mac_operand_feeder_if import mac_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;

  modport master (output in_valid, in_a, in_b, input in_ready);
  modport slave  (input in_valid, in_a, in_b, output in_ready);
endinterface

// File: rtl/operand_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty/level derived from pointer difference.
module operand_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand pairs and launches them into a sequential MAC with start/busy handshake.
module mac_operand_feeder import mac_pkg::*; #(
  parameter  int DATA_W       = DATA_W_DEF,
  parameter  int DEPTH        = DEPTH_DEF,
  parameter  int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter  int CNT_W        = CNT_W_DEF,
  localparam int LW           = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  mac_operand_feeder_if.slave in_if,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              start,
  input  logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  op_count,
  output logic [LW-1:0]     fifo_level,
  output logic              timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  feeder_state_t       state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic                start_q, start_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                pop;
  logic                fifo_full, fifo_empty;
  logic [2*DATA_W-1:0] head;

  operand_fifo #(.WIDTH(2*DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_if.in_valid),
    .wdata ({in_if.in_a, in_if.in_b}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign in_if.in_ready = !fifo_full;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    start_d = start_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        start_d = 1'b0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          a_d     = head[2*DATA_W-1:DATA_W];
          b_d     = head[DATA_W-1:0];
          start_d = 1'b1;
          timer_d = '0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (busy) begin
          start_d = 1'b0;
          state_d = RUN;
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          // MAC never acknowledged: drop the pair without counting it.
          start_d = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RUN: begin
        if (!busy) begin
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      start_q <= 1'b0;
      timer_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      start_q <= start_d;
      timer_q <= timer_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign a           = a_q;
  assign b           = b_q;
  assign start       = start_q;
  assign done        = done_q;
  assign op_count    = cnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder; the bench itself plays the MAC by driving busy.
module tb_mac_operand_feeder;

  logic       clk;
  logic       reset;
  logic [7:0] a, b;
  logic       start, busy, done, timeout_err;
  logic [3:0] op_count;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  mac_operand_feeder_if #(.DATA_W(8)) in_if ();

  mac_operand_feeder #(
    .DATA_W(8), .DEPTH(4), .BUSY_TIMEOUT(15), .CNT_W(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_if       (in_if),
    .a           (a),
    .b           (b),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .op_count    (op_count),
    .fifo_level  (fifo_level),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] pa, input logic [7:0] pb);
    in_if.in_valid = 1'b1;
    in_if.in_a     = pa;
    in_if.in_b     = pb;
    @(negedge clk);
    in_if.in_valid = 1'b0;
  endtask

  task automatic wait_start(input logic [7:0] ea, input logic [7:0] eb);
    int n = 0;
    while (start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", 32'(start), 32'(1));
    check("launch_a", 32'(a), 32'(ea));
    check("launch_b", 32'(b), 32'(eb));
  endtask

  task automatic end_op(input logic [7:0] ea, input logic [7:0] eb, input logic [3:0] cnt);
    busy = 1'b0;
    @(negedge clk);
    check("done_pulse", 32'(done), 32'(1));
    check("op_count", 32'(op_count), 32'(cnt));
    check("done_a_held", 32'(a), 32'(ea));
    check("done_b_held", 32'(b), 32'(eb));
  endtask

  task automatic run_op(input logic [7:0] ea, input logic [7:0] eb, input logic [3:0] cnt);
    wait_start(ea, eb);
    busy = 1'b1;
    repeat (9) begin
      @(negedge clk);
      check("run_start_low", 32'(start), 32'(0));
      check("run_a_stable", 32'(a), 32'(ea));
      check("run_b_stable", 32'(b), 32'(eb));
      check("run_no_done", 32'(done), 32'(0));
    end
    end_op(ea, eb, cnt);
  endtask

  initial begin
    int hi;
    int n;
    reset          = 1'b0;
    busy           = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_a     = '0;
    in_if.in_b     = '0;
    repeat (2) @(negedge clk);
    check("rst_start", 32'(start), 32'(0));
    check("rst_a", 32'(a), 32'(0));
    check("rst_b", 32'(b), 32'(0));
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_count", 32'(op_count), 32'(0));
    check("rst_err", 32'(timeout_err), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_ready", 32'(in_if.in_ready), 32'(1));
    reset = 1'b1;
    @(negedge clk);

    // Four back-to-back pairs, including a negative operand
    push(8'd3, 8'd17);
    push(8'd7, 8'd7);
    push(8'd8, 8'd9);
    push(8'hF8, 8'd5);
    check("t1_level", 32'(fifo_level), 32'(3));
    run_op(8'd3, 8'd17, 4'd1);
    run_op(8'd7, 8'd7, 4'd2);
    run_op(8'd8, 8'd9, 4'd3);
    run_op(8'hF8, 8'd5, 4'd4);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 32'(0));
    check("t1_err", 32'(timeout_err), 32'(0));
    check("t1_level_empty", 32'(fifo_level), 32'(0));

    // MAC stays busy while the FIFO fills
    push(8'd21, 8'hEB);
    wait_start(8'd21, 8'hEB);
    busy = 1'b1;
    @(negedge clk);
    push(8'd1, 8'd2);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    check("t2_full_level", 32'(fifo_level), 32'(4));
    check("t2_not_ready", 32'(in_if.in_ready), 32'(0));
    in_if.in_valid = 1'b1;
    in_if.in_a     = 8'd9;
    in_if.in_b     = 8'd10;
    repeat (3) @(negedge clk);
    check("t2_full_hold", 32'(fifo_level), 32'(4));
    check("t2_still_not_ready", 32'(in_if.in_ready), 32'(0));
    end_op(8'd21, 8'hEB, 4'd5);
    check("t2_level_after_done", 32'(fifo_level), 32'(4));
    @(negedge clk);
    check("t2_pop_level", 32'(fifo_level), 32'(3));
    check("t2_pop_start", 32'(start), 32'(1));
    check("t2_ready_again", 32'(in_if.in_ready), 32'(1));
    @(negedge clk);
    in_if.in_valid = 1'b0;
    check("t2_fifth_accepted", 32'(fifo_level), 32'(4));
    run_op(8'd1, 8'd2, 4'd6);
    run_op(8'd3, 8'd4, 4'd7);
    run_op(8'd5, 8'd6, 4'd8);
    run_op(8'd7, 8'd8, 4'd9);
    run_op(8'd9, 8'd10, 4'd10);

    // busy stuck low: start holds for exactly the timeout window
    push(8'd3, 8'd17);
    hi = 0;
    n  = 0;
    while (n < 60) begin
      @(negedge clk);
      if (start === 1'b1) hi++;
      else if (hi > 0) break;
      n++;
    end
    check("t3_start_cycles", 32'(hi), 32'(15));
    check("t3_err", 32'(timeout_err), 32'(1));
    check("t3_count", 32'(op_count), 32'(10));
    check("t3_level", 32'(fifo_level), 32'(0));
    repeat (3) @(negedge clk);
    check("t3_idle_start", 32'(start), 32'(0));
    check("t3_err_sticky", 32'(timeout_err), 32'(1));

    // Asynchronous reset mid-RUN with two pairs queued
    push(8'd1, 8'd2);
    wait_start(8'd1, 8'd2);
    busy = 1'b1;
    @(negedge clk);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    check("t4_queued", 32'(fifo_level), 32'(2));
    #3 reset = 1'b0;
    #1;
    check("t4_start", 32'(start), 32'(0));
    check("t4_a", 32'(a), 32'(0));
    check("t4_b", 32'(b), 32'(0));
    check("t4_level", 32'(fifo_level), 32'(0));
    check("t4_count", 32'(op_count), 32'(0));
    check("t4_ready", 32'(in_if.in_ready), 32'(1));
    check("t4_err", 32'(timeout_err), 32'(0));
    busy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push(8'd4, 8'hFD);
    run_op(8'd4, 8'hFD, 4'd1);

    // Push coinciding with an IDLE pop at level 2
    push(8'd10, 8'd20);
    wait_start(8'd10, 8'd20);
    busy = 1'b1;
    @(negedge clk);
    push(8'd11, 8'hFF);
    push(8'h80, 8'h7F);
    check("t5_level2", 32'(fifo_level), 32'(2));
    end_op(8'd10, 8'd20, 4'd2);
    in_if.in_valid = 1'b1;
    in_if.in_a     = 8'h7F;
    in_if.in_b     = 8'h80;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    check("t5_level_same", 32'(fifo_level), 32'(2));
    run_op(8'd11, 8'hFF, 4'd3);
    run_op(8'h80, 8'h7F, 4'd4);
    run_op(8'h7F, 8'h80, 4'd5);

    // op_count wraps in the 4-bit build
    for (int i = 0; i < 10; i++) begin
      push(8'(i + 1), 8'(i + 2));
      run_op(8'(i + 1), 8'(i + 2), 4'(6 + i));
    end
    check("t6_count_15", 32'(op_count), 32'(15));
    push(8'd100, 8'h9C);
    run_op(8'd100, 8'h9C, 4'd0);
    @(negedge clk);
    check("t6_done_clear", 32'(done), 32'(0));
    check("t6_count_wrapped", 32'(op_count), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
